execute_pipe: RTL and testbench
===============================

Name: execute_pipe

Overview:
- Registered, handshaked execute stage for the next-generation pipelined processor.
- Selects ALU operands (register, immediate, zero, MVHI merge), computes the ALU result and a real branch-condition flag, and registers both into a one-entry output buffer.
- Adds an iterative multi-cycle multiply mode that stalls the upstream stage.
- Sits between decode/register-read and memory/writeback; a flush input from branch resolution kills in-flight work.

Parameters:
- OPCODE_BIT_WIDTH, 4, width of opAlu and opCond.
- DBITS, 32, datapath width; must be at least 17.
- MUL_EN, 1, 1 enables the iterative multiply; 0 treats MUL as ADD.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetN  in  1  synchronous, active-low reset.
- flush  in  1  kill in-flight/buffered result this cycle.
- inValid  in  1  upstream operands valid.
- inReady  out  1  stage can accept this cycle.
- inRegd  in  DBITS  destination register old value (MVHI low half).
- inReg1  in  DBITS  source register 1.
- inReg2  in  DBITS  source register 2.
- imm32  in  DBITS  sign-extended immediate.
- immHi  in  16  MVHI upper immediate.
- useZero  in  1  operand B = 0.
- useImm  in  1  operand B = imm32 (when useZero=0).
- isMvhi  in  1  operand A = {immHi, inRegd[15:0]}, zero-extended above bit 31 if DBITS>32.
- opAlu  in  OPCODE_BIT_WIDTH  ALU operation.
- opCond  in  OPCODE_BIT_WIDTH  condition code.
- outValid  out  1  result valid.
- outReady  in  1  downstream consumes result.
- outAlu  out  DBITS  registered result.
- outCond  out  1  registered condition flag.
- busy  out  1  multiply in progress.

Behaviour:
- Reset (resetN=0 at clk edge):
  - outValid=0, outAlu=0, outCond=0, busy=0.
  - State=IDLE; any multiply is aborted.
- Operand selection: inA = isMvhi ? merge : inReg1; inB = useZero ? 0 : useImm ? imm32 : inReg2.
- opAlu encoding:
  - 0 ADD, 1 SUB, 4 AND, 5 OR, 6 XOR, 8 NAND, 9 NOR, 10 XNOR, 11 PASSA (MVHI), 12 MUL.
  - Other codes return 0.
  - All arithmetic is modulo 2^DBITS.
  - MUL keeps the low DBITS bits of the product.
- Condition:
  - Computed on D = inA − inB as a signed compare with overflow correction, independent of opAlu.
  - opCond: 0 F, 1 EQ, 2 LT, 3 LE, 8 T, 9 NE, 10 GE, 11 GT; other codes give 0.
- Handshake:
  - Transfer in when inValid && inReady.
  - Transfer out when outValid && outReady.
  - inReady = (state==IDLE) && (!outValid || outReady) && !flush.
- States:
  - IDLE:
    - On accept of a non-MUL op, the next edge loads outAlu/outCond and sets outValid=1 (latency 1).
    - On accept of MUL with MUL_EN=1, latch multiplicand, multiplier and outCond, then go to MUL_BUSY with counter=0 and busy=1.
    - On an output transfer with no accept, outValid clears.
    - Back-to-back single-cycle ops sustain 1 per cycle.
  - MUL_BUSY:
    - Shift-add one multiplier bit per cycle; counter increments.
    - When counter reaches DBITS−1, go to IDLE, write outAlu and set outValid=1.
    - Total latency is DBITS+1 edges from accept to outValid.
    - inReady=0 throughout.
- Output hold: while outValid && !outReady, outAlu/outCond are stable and no new accept occurs.
- Flush (resetN=1):
  - Next edge forces outValid=0, busy=0, state=IDLE; the multiply is discarded.
  - Flush wins over a simultaneous accept or output completion.
  - Data registers may keep stale values.
- Multiply completion while outReady=0: not possible, because MUL is accepted only with the output buffer empty or draining and the buffer is empty on completion.
- Reset overrides flush.

Test Plan:
- Reset: hold resetN=0 for 2 cycles with inValid=1 -> outValid=0, outAlu=0, busy=0; first accept occurs only after resetN=1.
- ADD with imm, then stall: inReg1=5, imm32=0xFFFFFFFF, useImm=1, opAlu=0, outReady=0 -> outAlu=4 one cycle later and held; inReady=0 until outReady=1.
- Conditions: inReg1=0x80000000, inReg2=1 -> LT=1, GT=0, NE=1; inReg1=inReg2=7 -> EQ=1, LE=1, GE=1; opCond=8 -> 1.
- MVHI: inRegd=0x1234ABCD, immHi=0xBEEF, opAlu=11 -> outAlu=0xBEEFABCD.
- MUL: 0xFFFFFFFF×3 -> outAlu=0xFFFFFFFD exactly 33 edges after accept; busy=1 and inReady=0 during the multiply; next op is accepted the cycle after.
- Flush mid-MUL at counter=10, with a simultaneous inValid -> busy=0 and outValid=0 next cycle; no result is emitted; the following ADD 2+2 returns 4 with latency 1.

Source files
------------

// File: rtl/execute_pipe_if.sv
// Operand/handshake bundle between register-read and the execute stage.
// master drives the operands and outReady; slave returns the result side.
interface execute_pipe_if #(
    parameter int unsigned OPCODE_BIT_WIDTH = 4,
    parameter int unsigned DBITS            = 32
);
    logic                        inValid;
    logic                        inReady;
    logic [DBITS-1:0]            inRegd;
    logic [DBITS-1:0]            inReg1;
    logic [DBITS-1:0]            inReg2;
    logic [DBITS-1:0]            imm32;
    logic [15:0]                 immHi;
    logic                        useZero;
    logic                        useImm;
    logic                        isMvhi;
    logic [OPCODE_BIT_WIDTH-1:0] opAlu;
    logic [OPCODE_BIT_WIDTH-1:0] opCond;
    logic                        outValid;
    logic                        outReady;
    logic [DBITS-1:0]            outAlu;
    logic                        outCond;
    logic                        busy;

    modport master (
        output inValid, inRegd, inReg1, inReg2, imm32, immHi, useZero, useImm, isMvhi,
               opAlu, opCond, outReady,
        input  inReady, outValid, outAlu, outCond, busy
    );

    modport slave (
        input  inValid, inRegd, inReg1, inReg2, imm32, immHi, useZero, useImm, isMvhi,
               opAlu, opCond, outReady,
        output inReady, outValid, outAlu, outCond, busy
    );
endinterface

// File: rtl/execute_pipe.sv
// Execute stage: operand select, ALU, branch condition, one-entry output buffer
// and an optional bit-serial shift-add multiplier that stalls upstream.
module execute_pipe #(
    parameter int unsigned OPCODE_BIT_WIDTH = 4,
    parameter int unsigned DBITS            = 32,
    parameter int unsigned MUL_EN           = 1
) (
    input logic           clk,
    input logic           resetN,
    input logic           flush,
    execute_pipe_if.slave bus
);
    localparam int unsigned CntW = $clog2(DBITS);
    localparam logic [CntW-1:0] CntLast = CntW'(DBITS - 1);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StMulBusy = 1'b1;

    localparam logic [OPCODE_BIT_WIDTH-1:0] OpAdd   = OPCODE_BIT_WIDTH'(0);
    localparam logic [OPCODE_BIT_WIDTH-1:0] OpSub   = OPCODE_BIT_WIDTH'(1);
    localparam logic [OPCODE_BIT_WIDTH-1:0] OpAnd   = OPCODE_BIT_WIDTH'(4);
    localparam logic [OPCODE_BIT_WIDTH-1:0] OpOr    = OPCODE_BIT_WIDTH'(5);
    localparam logic [OPCODE_BIT_WIDTH-1:0] OpXor   = OPCODE_BIT_WIDTH'(6);
    localparam logic [OPCODE_BIT_WIDTH-1:0] OpNand  = OPCODE_BIT_WIDTH'(8);
    localparam logic [OPCODE_BIT_WIDTH-1:0] OpNor   = OPCODE_BIT_WIDTH'(9);
    localparam logic [OPCODE_BIT_WIDTH-1:0] OpXnor  = OPCODE_BIT_WIDTH'(10);
    localparam logic [OPCODE_BIT_WIDTH-1:0] OpPassA = OPCODE_BIT_WIDTH'(11);
    localparam logic [OPCODE_BIT_WIDTH-1:0] OpMul   = OPCODE_BIT_WIDTH'(12);

    localparam logic [OPCODE_BIT_WIDTH-1:0] CondF  = OPCODE_BIT_WIDTH'(0);
    localparam logic [OPCODE_BIT_WIDTH-1:0] CondEq = OPCODE_BIT_WIDTH'(1);
    localparam logic [OPCODE_BIT_WIDTH-1:0] CondLt = OPCODE_BIT_WIDTH'(2);
    localparam logic [OPCODE_BIT_WIDTH-1:0] CondLe = OPCODE_BIT_WIDTH'(3);
    localparam logic [OPCODE_BIT_WIDTH-1:0] CondT  = OPCODE_BIT_WIDTH'(8);
    localparam logic [OPCODE_BIT_WIDTH-1:0] CondNe = OPCODE_BIT_WIDTH'(9);
    localparam logic [OPCODE_BIT_WIDTH-1:0] CondGe = OPCODE_BIT_WIDTH'(10);
    localparam logic [OPCODE_BIT_WIDTH-1:0] CondGt = OPCODE_BIT_WIDTH'(11);

    logic [0:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DBITS-1:0] mcand_q, mcand_d;
    logic [DBITS-1:0] mplier_q, mplier_d;
    logic [DBITS-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [DBITS-1:0] out_alu_q, out_alu_d;
    logic             out_cond_q, out_cond_d;

    logic [DBITS+31:0] merge_wide;
    logic [DBITS-1:0]  op_a, op_b, diff, alu_res, acc_step;
    logic              sign_ovf_lt, is_zero, cond_res;
    logic              in_ready, accept, is_mul;

    // MVHI operand: upper immediate over the old low half, zero above bit 31.
    assign merge_wide = {{DBITS{1'b0}}, bus.immHi, bus.inRegd[15:0]};

    always_comb begin
        op_a = bus.isMvhi ? merge_wide[DBITS-1:0] : bus.inReg1;
        if (bus.useZero) begin
            op_b = '0;
        end else if (bus.useImm) begin
            op_b = bus.imm32;
        end else begin
            op_b = bus.inReg2;
        end
    end

    // Signed less-than from the subtraction: N xor V.
    assign diff        = op_a - op_b;
    assign is_zero     = (diff == '0);
    assign sign_ovf_lt = diff[DBITS-1] ^
                         ((op_a[DBITS-1] ^ op_b[DBITS-1]) & (diff[DBITS-1] ^ op_a[DBITS-1]));

    always_comb begin
        cond_res = 1'b0;
        case (bus.opCond)
            CondF:   cond_res = 1'b0;
            CondEq:  cond_res = is_zero;
            CondLt:  cond_res = sign_ovf_lt;
            CondLe:  cond_res = sign_ovf_lt | is_zero;
            CondT:   cond_res = 1'b1;
            CondNe:  cond_res = ~is_zero;
            CondGe:  cond_res = ~sign_ovf_lt;
            CondGt:  cond_res = ~sign_ovf_lt & ~is_zero;
            default: cond_res = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (bus.opAlu)
            OpAdd:   alu_res = op_a + op_b;
            OpSub:   alu_res = diff;
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpXor:   alu_res = op_a ^ op_b;
            OpNand:  alu_res = ~(op_a & op_b);
            OpNor:   alu_res = ~(op_a | op_b);
            OpXnor:  alu_res = ~(op_a ^ op_b);
            OpPassA: alu_res = op_a;
            OpMul:   alu_res = (MUL_EN != 0) ? '0 : op_a + op_b;
            default: alu_res = '0;
        endcase
    end

    assign is_mul   = (MUL_EN != 0) && (bus.opAlu == OpMul);
    assign in_ready = (state_q == StIdle) && (!out_valid_q || bus.outReady) && !flush;
    assign accept   = bus.inValid && in_ready;
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_alu_d   = out_alu_q;
        out_cond_d  = out_cond_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
        end else if (state_q == StMulBusy) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
                state_d     = StIdle;
                out_alu_d   = acc_step;
                out_valid_d = 1'b1;
            end
        end else if (accept) begin
            out_cond_d = cond_res;
            if (is_mul) begin
                // Buffer is empty or draining this edge, so it stays empty until done.
                state_d     = StMulBusy;
                cnt_d       = '0;
                mcand_d     = op_a;
                mplier_d    = op_b;
                acc_d       = '0;
                out_valid_d = 1'b0;
            end else begin
                out_alu_d   = alu_res;
                out_valid_d = 1'b1;
            end
        end else if (out_valid_q && bus.outReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_alu_q   <= '0;
            out_cond_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_alu_q   <= out_alu_d;
            out_cond_q  <= out_cond_d;
        end
    end

    assign bus.inReady  = in_ready;
    assign bus.outValid = out_valid_q;
    assign bus.outAlu   = out_alu_q;
    assign bus.outCond  = out_cond_q;
    assign bus.busy     = (state_q == StMulBusy);
endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed scenarios with literal expectations, then
// randomized traffic compared each cycle against a transaction-level model.
module tb_execute_pipe;
    localparam int unsigned DBITS = 32;

    logic clk = 1'b0;
    logic resetN;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    execute_pipe_if #(.OPCODE_BIT_WIDTH(4), .DBITS(DBITS)) bus ();

    execute_pipe #(.OPCODE_BIT_WIDTH(4), .DBITS(DBITS), .MUL_EN(1)) dut (
        .clk    (clk),
        .resetN (resetN),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        model_known = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_alu = '0;
    logic        m_cond = 1'b0;
    int          m_pend = 0;
    logic [31:0] m_prod = '0;

    function automatic logic [31:0] ref_a();
        logic [31:0] merged;
        merged = {bus.immHi, bus.inRegd[15:0]};
        return bus.isMvhi ? merged : bus.inReg1;
    endfunction

    function automatic logic [31:0] ref_b();
        if (bus.useZero) return 32'd0;
        return bus.useImm ? bus.imm32 : bus.inReg2;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd8:    return ~(a & b);
            4'd9:    return ~(a | b);
            4'd10:   return ~(a ^ b);
            4'd11:   return a;
            4'd12:   return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] c);
        logic lt, eq;
        lt = $signed(a) < $signed(b);
        eq = (a == b);
        case (c)
            4'd1:    return eq;
            4'd2:    return lt;
            4'd3:    return lt || eq;
            4'd8:    return 1'b1;
            4'd9:    return !eq;
            4'd10:   return !lt;
            4'd11:   return !lt && !eq;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_ready();
        return (m_pend == 0) && (!m_valid || bus.outReady) && !flush;
    endfunction

    always @(posedge clk) begin
        logic        rdy;
        logic [31:0] a, b;
        rdy = m_ready();
        a   = ref_a();
        b   = ref_b();
        if (!resetN) begin
            model_known = 1'b1;
            m_valid = 1'b0;
            m_alu   = '0;
            m_cond  = 1'b0;
            m_pend  = 0;
        end else if (flush) begin
            m_valid = 1'b0;
            m_pend  = 0;
        end else if (m_pend != 0) begin
            m_pend--;
            if (m_pend == 0) begin
                m_valid = 1'b1;
                m_alu   = m_prod;
            end
        end else if (bus.inValid && rdy) begin
            m_cond = ref_cond(a, b, bus.opCond);
            if (bus.opAlu == 4'd12) begin
                m_prod  = ref_alu(a, b, bus.opAlu);
                m_pend  = DBITS;
                m_valid = 1'b0;
            end else begin
                m_alu   = ref_alu(a, b, bus.opAlu);
                m_valid = 1'b1;
            end
        end else if (m_valid && bus.outReady) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        #1;
        if (model_known) begin
            chk("outValid", 32'(bus.outValid), 32'(m_valid));
            chk("busy", 32'(bus.busy), 32'(m_pend != 0));
            chk("inReady", 32'(bus.inReady), 32'(m_ready()));
            if (m_valid) begin
                chk("outAlu", bus.outAlu, m_alu);
                chk("outCond", 32'(bus.outCond), 32'(m_cond));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic clear_ops();
        bus.inValid = 1'b0; bus.inRegd = '0; bus.inReg1 = '0; bus.inReg2 = '0;
        bus.imm32 = '0; bus.immHi = '0; bus.useZero = 1'b0; bus.useImm = 1'b0;
        bus.isMvhi = 1'b0; bus.opAlu = '0; bus.opCond = '0;
    endtask

    // Caller sets operands at a falling edge; issue and check one cycle later.
    task automatic fire(input string name, input logic [31:0] ea, input logic ec);
        bus.inValid  = 1'b1;
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.inValid = 1'b0;
        #2;
        chk({name, "_valid"}, 32'(bus.outValid), 32'd1);
        chk({name, "_alu"}, bus.outAlu, ea);
        chk({name, "_cond"}, 32'(bus.outCond), 32'(ec));
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 8));
            1:       return 32'h8000_0000 ^ 32'($urandom_range(0, 3));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int stall_bad;
        int stray;
        resetN = 1'b0;
        flush  = 1'b0;
        clear_ops();
        bus.inReg1 = 32'd1; bus.inReg2 = 32'd1;
        bus.inValid = 1'b1; bus.outReady = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_valid", 32'(bus.outValid), 32'd0);
        chk("rst_alu", bus.outAlu, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // ADD with immediate, then hold under back-pressure
        resetN = 1'b1;
        clear_ops();
        bus.inReg1 = 32'd5; bus.imm32 = 32'hFFFF_FFFF; bus.useImm = 1'b1;
        bus.inValid = 1'b1; bus.outReady = 1'b0;
        @(negedge clk);
        bus.inReg1 = 32'd100;
        #2;
        chk("add_imm_alu", bus.outAlu, 32'd4);
        chk("add_imm_valid", 32'(bus.outValid), 32'd1);
        chk("hold_ready", 32'(bus.inReady), 32'd0);
        repeat (2) begin
            @(negedge clk); #2;
            chk("hold_alu", bus.outAlu, 32'd4);
            chk("hold_ready", 32'(bus.inReady), 32'd0);
        end
        @(negedge clk);
        bus.outReady = 1'b1;
        #2;
        chk("drain_ready", 32'(bus.inReady), 32'd1);
        @(negedge clk);
        bus.inValid = 1'b0;
        #2;
        chk("after_drain_alu", bus.outAlu, 32'd99);

        // Conditions
        @(negedge clk); clear_ops();
        bus.inReg1 = 32'h8000_0000; bus.inReg2 = 32'd1; bus.opCond = 4'd2;
        fire("lt", 32'h8000_0001, 1'b1);
        @(negedge clk); clear_ops();
        bus.inReg1 = 32'h8000_0000; bus.inReg2 = 32'd1; bus.opCond = 4'd11;
        fire("gt", 32'h8000_0001, 1'b0);
        @(negedge clk); clear_ops();
        bus.inReg1 = 32'h8000_0000; bus.inReg2 = 32'd1; bus.opCond = 4'd9;
        fire("ne", 32'h8000_0001, 1'b1);
        @(negedge clk); clear_ops();
        bus.inReg1 = 32'd7; bus.inReg2 = 32'd7; bus.opAlu = 4'd1; bus.opCond = 4'd1;
        fire("eq", 32'd0, 1'b1);
        @(negedge clk); clear_ops();
        bus.inReg1 = 32'd7; bus.inReg2 = 32'd7; bus.opCond = 4'd3;
        fire("le", 32'd14, 1'b1);
        @(negedge clk); clear_ops();
        bus.inReg1 = 32'd7; bus.inReg2 = 32'd7; bus.opCond = 4'd10;
        fire("ge", 32'd14, 1'b1);
        @(negedge clk); clear_ops();
        bus.inReg1 = 32'd3; bus.inReg2 = 32'd9; bus.opAlu = 4'd6; bus.opCond = 4'd8;
        fire("true", 32'd10, 1'b1);

        // MVHI
        @(negedge clk); clear_ops();
        bus.inRegd = 32'h1234_ABCD; bus.immHi = 16'hBEEF; bus.isMvhi = 1'b1;
        bus.opAlu = 4'd11;
        fire("mvhi", 32'hBEEF_ABCD, 1'b0);

        // MUL latency and stall, next op queued behind it
        @(negedge clk); clear_ops();
        bus.inReg1 = 32'hFFFF_FFFF; bus.inReg2 = 32'd3; bus.opAlu = 4'd12; bus.opCond = 4'd9;
        bus.inValid = 1'b1; bus.outReady = 1'b1;
        @(negedge clk);
        bus.inReg1 = 32'd2; bus.opAlu = 4'd0; bus.opCond = 4'd0;
        #2;
        n = 1;
        stall_bad = 0;
        while (!bus.outValid && n < 40) begin
            if (!bus.busy || bus.inReady) stall_bad++;
            @(negedge clk); #2;
            n++;
        end
        chk("mul_latency", 32'(n), 32'd33);
        chk("mul_stall", 32'(stall_bad), 32'd0);
        chk("mul_alu", bus.outAlu, 32'hFFFF_FFFD);
        chk("mul_cond", 32'(bus.outCond), 32'd1);
        chk("mul_done_ready", 32'(bus.inReady), 32'd1);
        @(negedge clk);
        bus.inValid = 1'b0;
        #2;
        chk("post_mul_alu", bus.outAlu, 32'd5);

        // Flush mid-multiply with a simultaneous request
        @(negedge clk); clear_ops();
        bus.inReg1 = 32'd123; bus.inReg2 = 32'd456; bus.opAlu = 4'd12;
        bus.inValid = 1'b1; bus.outReady = 1'b1;
        @(negedge clk);
        bus.inValid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        bus.inValid = 1'b1; bus.opAlu = 4'd0; bus.inReg1 = 32'd9; bus.inReg2 = 32'd9;
        #2;
        chk("flush_mid_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        bus.inValid = 1'b0;
        #2;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_valid", 32'(bus.outValid), 32'd0);
        stray = 0;
        repeat (40) begin
            @(negedge clk); #2;
            if (bus.outValid) stray++;
        end
        chk("flush_no_result", 32'(stray), 32'd0);
        @(negedge clk); clear_ops();
        bus.inReg1 = 32'd2; bus.inReg2 = 32'd2;
        fire("post_flush_add", 32'd4, 1'b0);

        // Randomized traffic, one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            resetN       = !(i >= 1500 && i < 1502);
            flush        = ($urandom_range(0, 49) == 0);
            bus.inValid  = ($urandom_range(0, 9) < 6);
            bus.outReady = ($urandom_range(0, 3) != 0);
            bus.opAlu    = ($urandom_range(0, 9) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
            bus.opCond   = 4'($urandom_range(0, 15));
            bus.inReg1   = rand_word();
            bus.inReg2   = ($urandom_range(0, 5) == 0) ? bus.inReg1 : rand_word();
            bus.imm32    = rand_word();
            bus.inRegd   = $urandom;
            bus.immHi    = 16'($urandom_range(0, 65535));
            bus.useZero  = ($urandom_range(0, 6) == 0);
            bus.useImm   = ($urandom_range(0, 2) == 0);
            bus.isMvhi   = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
